// File: rtl/type_pkg.sv
// Shared types for the write path: burst encoding, write-command payload and window slot.
package type_pkg;

   localparam int unsigned WCQ_DEPTH_DEFAULT = 8;
   localparam int unsigned WCQ_DATA_SIZE     = 64;
   localparam int unsigned WCQ_ADDR_SIZE     = 8;

   typedef enum logic [1:0] {
      ONE_BYTE   = 2'd0,
      TWO_BYTE   = 2'd1,
      FOUR_BYTE  = 2'd2,
      EIGHT_BYTE = 2'd3
   } burst_size_t;

   typedef struct packed {
      logic [WCQ_DATA_SIZE-1:0] data;
      logic [WCQ_ADDR_SIZE-1:0] addr;
      burst_size_t              burst_size;
   } write_info_t;

   typedef struct packed {
      logic [WCQ_ADDR_SIZE-1:0] addr;
      burst_size_t              burst_size;
   } wcq_slot_t;

endpackage

// File: rtl/wcq_window_mux.sv
// Read window: presents the LOOKAHEAD oldest entries starting at rptr, wrapping mod DEPTH.
module wcq_window_mux
   import type_pkg::*;
#(
   parameter int unsigned DEPTH     = WCQ_DEPTH_DEFAULT,
   parameter int unsigned DATA_SIZE = WCQ_DATA_SIZE,
   parameter int unsigned ADDR_SIZE = WCQ_ADDR_SIZE,
   parameter int unsigned LOOKAHEAD = 2,
   localparam int unsigned PW       = $clog2(DEPTH),
   localparam int unsigned CW       = PW + 1
) (
   input  logic [PW-1:0]                  rptr,
   input  logic [CW-1:0]                  count,
   input  logic [DATA_SIZE-1:0]           mem_data  [DEPTH],
   input  logic [ADDR_SIZE-1:0]           mem_addr  [DEPTH],
   input  burst_size_t                    mem_burst [DEPTH],
   output logic [LOOKAHEAD-1:0]           win_valid,
   output logic [LOOKAHEAD*DATA_SIZE-1:0] win_data,
   output logic [LOOKAHEAD*ADDR_SIZE-1:0] win_addr,
   output burst_size_t [LOOKAHEAD-1:0]    win_burst
);

   for (genvar k = 0; k < LOOKAHEAD; k++) begin : g_slot
      logic [PW-1:0] idx;

      assign idx                                 = rptr + PW'(k);
      assign win_valid[k]                        = (count > CW'(k));
      assign win_data[k*DATA_SIZE +: DATA_SIZE]  = mem_data[idx];
      assign win_addr[k*ADDR_SIZE +: ADDR_SIZE]  = mem_addr[idx];
      assign win_burst[k]                        = mem_burst[idx];
   end

endmodule

// File: rtl/write_command_queue.sv
// Write-command FIFO feeding the DDR scheduler: lookahead window, multi-entry retire,
// flush, almost-full watermark, overflow/underflow pulses and occupancy.
module write_command_queue
   import type_pkg::*;
#(
   parameter int unsigned DEPTH       = WCQ_DEPTH_DEFAULT,
   parameter int unsigned DATA_SIZE   = WCQ_DATA_SIZE,
   parameter int unsigned ADDR_SIZE   = WCQ_ADDR_SIZE,
   parameter int unsigned LOOKAHEAD   = 2,
   parameter int unsigned AFULL_LEVEL = 6,
   localparam int unsigned PW         = $clog2(DEPTH),
   localparam int unsigned CW         = PW + 1,
   localparam int unsigned NW         = $clog2(LOOKAHEAD + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wstrobe,
   input  logic [1:0]                     burst_size,
   input  logic [DATA_SIZE-1:0]           wdata,
   input  logic [ADDR_SIZE-1:0]           waddr,
   input  logic [NW-1:0]                  pop_num,
   input  logic                           flush,
   output logic [LOOKAHEAD-1:0]           win_valid,
   output logic [LOOKAHEAD*DATA_SIZE-1:0] win_data,
   output logic [LOOKAHEAD*ADDR_SIZE-1:0] win_addr,
   output burst_size_t [LOOKAHEAD-1:0]    win_burst,
   output logic [CW-1:0]                  count,
   output logic                           wfull,
   output logic                           almost_full,
   output logic                           werr,
   output logic                           uerr,
   output burst_size_t                    last_pop_burst
);

   logic [DATA_SIZE-1:0] mem_data  [DEPTH];
   logic [ADDR_SIZE-1:0] mem_addr  [DEPTH];
   burst_size_t          mem_burst [DEPTH];

   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;

   logic          push_acc_c;
   logic          pop_ok_c;
   logic          pop_over_c;
   logic [CW-1:0] pop_amt_c;
   logic [CW-1:0] next_count_c;
   logic [PW-1:0] last_idx_c;

   // Accept/reject decisions are taken from registered occupancy only.
   always_comb begin
      push_acc_c   = wstrobe & ~wfull;
      pop_over_c   = (CW'(pop_num) > count);
      pop_ok_c     = (pop_num != '0) & ~pop_over_c;
      pop_amt_c    = pop_ok_c ? CW'(pop_num) : '0;
      last_idx_c   = rptr + PW'(pop_num) - PW'(1);
      next_count_c = count + CW'(push_acc_c) - pop_amt_c;
      if (flush) begin
         next_count_c = '0;
      end
   end

   // Storage and write pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_data[i]  <= '0;
            mem_addr[i]  <= '0;
            mem_burst[i] <= ONE_BYTE;
         end
      end else if (flush) begin
         wptr <= '0;
      end else if (push_acc_c) begin
         mem_data[wptr]  <= wdata;
         mem_addr[wptr]  <= waddr;
         mem_burst[wptr] <= burst_size_t'(burst_size);
         wptr            <= wptr + PW'(1);
      end
   end

   // Read pointer, occupancy and retired-burst tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rptr           <= '0;
         count          <= '0;
         last_pop_burst <= ONE_BYTE;
      end else begin
         count <= next_count_c;
         if (flush) begin
            rptr <= '0;
         end else if (pop_ok_c) begin
            rptr           <= rptr + PW'(pop_num);
            last_pop_burst <= mem_burst[last_idx_c];
         end
      end
   end

   // Status flags track next_count so they line up with the registered count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wfull       <= 1'b0;
         almost_full <= 1'b0;
         werr        <= 1'b0;
         uerr        <= 1'b0;
      end else begin
         wfull       <= (next_count_c == CW'(DEPTH));
         almost_full <= (next_count_c >= CW'(AFULL_LEVEL));
         werr        <= wstrobe & wfull & ~flush;
         uerr        <= pop_over_c & ~flush;
      end
   end

   wcq_window_mux #(
      .DEPTH     (DEPTH),
      .DATA_SIZE (DATA_SIZE),
      .ADDR_SIZE (ADDR_SIZE),
      .LOOKAHEAD (LOOKAHEAD)
   ) u_window_mux (
      .rptr      (rptr),
      .count     (count),
      .mem_data  (mem_data),
      .mem_addr  (mem_addr),
      .mem_burst (mem_burst),
      .win_valid (win_valid),
      .win_data  (win_data),
      .win_addr  (win_addr),
      .win_burst (win_burst)
   );

endmodule

// File: tb/tb_write_command_queue.sv
// Directed self-checking bench for write_command_queue (DEPTH=8, LOOKAHEAD=2, AFULL_LEVEL=6).
module tb_write_command_queue;
   import type_pkg::*;

   localparam int unsigned DEPTH       = 8;
   localparam int unsigned DATA_SIZE   = 64;
   localparam int unsigned ADDR_SIZE   = 8;
   localparam int unsigned LOOKAHEAD   = 2;
   localparam int unsigned AFULL_LEVEL = 6;
   localparam int unsigned CW          = 4;
   localparam int unsigned NW          = 2;

   logic                           clk;
   logic                           rst;
   logic                           wstrobe;
   logic [1:0]                     burst_size;
   logic [DATA_SIZE-1:0]           wdata;
   logic [ADDR_SIZE-1:0]           waddr;
   logic [NW-1:0]                  pop_num;
   logic                           flush;
   logic [LOOKAHEAD-1:0]           win_valid;
   logic [LOOKAHEAD*DATA_SIZE-1:0] win_data;
   logic [LOOKAHEAD*ADDR_SIZE-1:0] win_addr;
   burst_size_t [LOOKAHEAD-1:0]    win_burst;
   logic [CW-1:0]                  count;
   logic                           wfull;
   logic                           almost_full;
   logic                           werr;
   logic                           uerr;
   burst_size_t                    last_pop_burst;

   int vec_cnt = 0;
   int err_cnt = 0;

   write_command_queue #(
      .DEPTH       (DEPTH),
      .DATA_SIZE   (DATA_SIZE),
      .ADDR_SIZE   (ADDR_SIZE),
      .LOOKAHEAD   (LOOKAHEAD),
      .AFULL_LEVEL (AFULL_LEVEL)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .wstrobe        (wstrobe),
      .burst_size     (burst_size),
      .wdata          (wdata),
      .waddr          (waddr),
      .pop_num        (pop_num),
      .flush          (flush),
      .win_valid      (win_valid),
      .win_data       (win_data),
      .win_addr       (win_addr),
      .win_burst      (win_burst),
      .count          (count),
      .wfull          (wfull),
      .almost_full    (almost_full),
      .werr           (werr),
      .uerr           (uerr),
      .last_pop_burst (last_pop_burst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus encoding: entry i carries addr i, data {DA7A0000,i}, burst (3i+1) mod 4.
   function automatic burst_size_t burst_of(input int i);
      return burst_size_t'(2'((i * 3 + 1) % 4));
   endfunction

   function automatic logic [63:0] data_of(input int i);
      return {32'hDA7A_0000, 32'(i)};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      wstrobe = 1'b0;
      pop_num = '0;
      flush   = 1'b0;
   endtask

   task automatic set_push(input int i);
      wstrobe    = 1'b1;
      waddr      = 8'(i);
      wdata      = data_of(i);
      burst_size = 2'(burst_of(i));
   endtask

   task automatic do_flush;
      idle_inputs();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic fill(input int base, input int n);
      pop_num = '0;
      for (int i = 0; i < n; i++) begin
         set_push(base + i);
         tick();
      end
      wstrobe = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      vec_cnt++;
      if (count !== 4'd0 || win_valid !== 2'b00) begin
         err_cnt++;
         $display("FAIL reset_init_count: count=%0d win_valid=%b exp 0/00", count, win_valid);
      end
      vec_cnt++;
      if ({wfull, almost_full, werr, uerr} !== 4'b0000 || last_pop_burst !== ONE_BYTE) begin
         err_cnt++;
         $display("FAIL reset_init_flags: flags=%b last=%0d exp 0000/0",
                  {wfull, almost_full, werr, uerr}, last_pop_burst);
      end
      rst = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         set_push(i);
         tick();
      end
      set_push(3);
      pop_num = 2'd1;
      tick();
      vec_cnt++;
      if (count !== 4'd3 || last_pop_burst !== TWO_BYTE) begin
         err_cnt++;
         $display("FAIL reset_pre_state: count=%0d last=%0d exp 3/1", count, last_pop_burst);
      end
      set_push(4);
      pop_num = '0;
      rst     = 1'b1;
      #1;
      vec_cnt++;
      if (count !== 4'd0 || win_valid !== 2'b00) begin
         err_cnt++;
         $display("FAIL reset_async_count: count=%0d win_valid=%b exp 0/00", count, win_valid);
      end
      vec_cnt++;
      if (last_pop_burst !== ONE_BYTE || werr !== 1'b0 || uerr !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_async_flags: last=%0d werr=%b uerr=%b exp 0/0/0",
                  last_pop_burst, werr, uerr);
      end
      tick();
      idle_inputs();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fill_overflow;
      int exp_cnt;
      for (int i = 0; i < 9; i++) begin
         set_push(i);
         tick();
         exp_cnt = (i < 8) ? i + 1 : 8;
         vec_cnt++;
         if (count !== 4'(exp_cnt) || almost_full !== (exp_cnt >= 6) ||
             wfull !== (exp_cnt == 8) || werr !== (i == 8)) begin
            err_cnt++;
            $display("FAIL fill_push%0d: count=%0d af=%b full=%b werr=%b exp %0d/%b/%b/%b",
                     i, count, almost_full, wfull, werr, exp_cnt,
                     exp_cnt >= 6, exp_cnt == 8, i == 8);
         end
      end
      idle_inputs();
      vec_cnt++;
      if (win_addr !== 16'h0100 || win_valid !== 2'b11 || win_data[63:0] !== data_of(0) ||
          win_burst[1] !== burst_of(1)) begin
         err_cnt++;
         $display("FAIL fill_window: addr=%h valid=%b d0=%h b1=%0d exp 0100/11/%h/%0d",
                  win_addr, win_valid, win_data[63:0], win_burst[1], data_of(0), burst_of(1));
      end
      tick();
      vec_cnt++;
      if (werr !== 1'b0 || count !== 4'd8) begin
         err_cnt++;
         $display("FAIL fill_werr_pulse: werr=%b count=%0d exp 0/8", werr, count);
      end
   endtask

   task automatic test_multi_pop_wrap;
      do_flush();
      fill(0, 8);
      for (int j = 0; j < 3; j++) begin
         pop_num = 2'd2;
         tick();
         vec_cnt++;
         if (count !== 4'(8 - 2 * (j + 1)) || win_addr[7:0] !== 8'(2 * (j + 1))) begin
            err_cnt++;
            $display("FAIL wrap_pop%0d: count=%0d slot0=%0d exp %0d/%0d",
                     j, count, win_addr[7:0], 8 - 2 * (j + 1), 2 * (j + 1));
         end
      end
      fill(8, 4);
      vec_cnt++;
      if (count !== 4'd6 || almost_full !== 1'b1) begin
         err_cnt++;
         $display("FAIL wrap_refill: count=%0d af=%b exp 6/1", count, almost_full);
      end
      pop_num = 2'd2;
      tick();
      pop_num = '0;
      vec_cnt++;
      if (win_addr !== 16'h0908 || count !== 4'd4 || win_valid !== 2'b11) begin
         err_cnt++;
         $display("FAIL wrap_window: addr=%h count=%0d valid=%b exp 0908/4/11",
                  win_addr, count, win_valid);
      end
      vec_cnt++;
      if (last_pop_burst !== FOUR_BYTE || win_burst[0] !== burst_of(8)) begin
         err_cnt++;
         $display("FAIL wrap_last_burst: last=%0d b0=%0d exp 2/%0d",
                  last_pop_burst, win_burst[0], burst_of(8));
      end
   endtask

   task automatic test_simultaneous;
      do_flush();
      fill(4, 1);
      set_push(5);
      pop_num = 2'd1;
      tick();
      idle_inputs();
      vec_cnt++;
      if (count !== 4'd1 || win_addr[7:0] !== 8'd5 || win_valid !== 2'b01) begin
         err_cnt++;
         $display("FAIL simul_push_pop: count=%0d slot0=%0d valid=%b exp 1/5/01",
                  count, win_addr[7:0], win_valid);
      end
      vec_cnt++;
      if (last_pop_burst !== TWO_BYTE || werr !== 1'b0 || uerr !== 1'b0) begin
         err_cnt++;
         $display("FAIL simul_flags: last=%0d werr=%b uerr=%b exp 1/0/0",
                  last_pop_burst, werr, uerr);
      end
   endtask

   task automatic test_full_pop_push;
      do_flush();
      fill(0, 8);
      set_push(20);
      pop_num = 2'd2;
      tick();
      idle_inputs();
      vec_cnt++;
      if (werr !== 1'b1 || count !== 4'd6 || wfull !== 1'b0 || almost_full !== 1'b1) begin
         err_cnt++;
         $display("FAIL fullpop_flags: werr=%b count=%0d full=%b af=%b exp 1/6/0/1",
                  werr, count, wfull, almost_full);
      end
      for (int j = 0; j < 3; j++) begin
         pop_num = 2'd2;
         tick();
         vec_cnt++;
         if (count !== 4'(4 - 2 * j) || (j < 2 && win_addr !== {8'(5 + 2 * j), 8'(4 + 2 * j)})) begin
            err_cnt++;
            $display("FAIL fullpop_drain%0d: count=%0d addr=%h exp %0d/%h",
                     j, count, win_addr, 4 - 2 * j, {8'(5 + 2 * j), 8'(4 + 2 * j)});
         end
      end
      pop_num = '0;
      vec_cnt++;
      if (win_valid !== 2'b00 || last_pop_burst !== FOUR_BYTE) begin
         err_cnt++;
         $display("FAIL fullpop_empty: valid=%b last=%0d exp 00/2", win_valid, last_pop_burst);
      end
   endtask

   task automatic test_underflow_flush;
      do_flush();
      fill(30, 1);
      pop_num = 2'd2;
      tick();
      pop_num = '0;
      vec_cnt++;
      if (uerr !== 1'b1 || count !== 4'd1 || win_addr[7:0] !== 8'd30 ||
          last_pop_burst !== FOUR_BYTE) begin
         err_cnt++;
         $display("FAIL uflow: uerr=%b count=%0d slot0=%0d last=%0d exp 1/1/30/2",
                  uerr, count, win_addr[7:0], last_pop_burst);
      end
      flush = 1'b1;
      set_push(31);
      tick();
      idle_inputs();
      vec_cnt++;
      if (count !== 4'd0 || werr !== 1'b0 || uerr !== 1'b0 || win_valid !== 2'b00) begin
         err_cnt++;
         $display("FAIL flush_push: count=%0d werr=%b uerr=%b valid=%b exp 0/0/0/00",
                  count, werr, uerr, win_valid);
      end
      fill(40, 8);
      flush = 1'b1;
      set_push(48);
      tick();
      idle_inputs();
      vec_cnt++;
      if (werr !== 1'b0 || count !== 4'd0 || wfull !== 1'b0 || almost_full !== 1'b0) begin
         err_cnt++;
         $display("FAIL flush_full: werr=%b count=%0d full=%b af=%b exp 0/0/0/0",
                  werr, count, wfull, almost_full);
      end
      fill(50, 1);
      vec_cnt++;
      if (win_addr[7:0] !== 8'd50 || count !== 4'd1 || win_valid !== 2'b01) begin
         err_cnt++;
         $display("FAIL flush_restart: slot0=%0d count=%0d valid=%b exp 50/1/01",
                  win_addr[7:0], count, win_valid);
      end
   endtask

   initial begin
      rst        = 1'b1;
      wstrobe    = 1'b0;
      burst_size = 2'd0;
      wdata      = '0;
      waddr      = '0;
      pop_num    = '0;
      flush      = 1'b0;
      test_reset();
      test_fill_overflow();
      test_multi_pop_wrap();
      test_simultaneous();
      test_full_pop_push();
      test_underflow_flush();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
